gcd_engine: RTL and testbench



---
 rtl/gcd_pkg.sv | 31 +++
 rtl/gcd_engine_dp.sv | 83 ++++++++
 rtl/gcd_engine.sv | 123 ++++++++++++
 tb/tb_gcd_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared constants, types and helpers for the GCD engine
//
// Purpose:
//   State encoding of the control FSM, the datapath operation selector,
//   the default operand width and the iteration-counter width derivation.
//   Imported by gcd_engine and gcd_engine_dp.
package gcd_pkg;

  // Default operand/result width in bits.
  localparam int GCD_WIDTH_DEFAULT = 6;

  // Control FSM encoding, kept as plain 2-bit constants.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operation the control FSM asks the datapath to perform this cycle.
  typedef enum logic [1:0] {
    DP_HOLD = 2'd0,  // keep A, B and the counter
    DP_LOAD = 2'd1,  // A<-a_in, B<-b_in, cnt<-0
    DP_SWAP = 2'd2,  // A<->B, cnt+1
    DP_SUB  = 2'd3   // A<-A-B, cnt+1
  } dp_op_e;

  // Iteration-counter width. The longest run is (2^W-1, 1), which needs
  // 2^W+1 steps, so one bit beyond the operand width is always enough.
  function automatic int gcd_cw(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/gcd_engine_dp.sv
// rtl/gcd_engine_dp.sv - GCD datapath: A/B registers, swap/subtract mux, compares, counter
//
// Purpose:
//   Executes one operation per cycle as selected by the control FSM and
//   reports the two status flags the FSM branches on.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   op_i      in   operation for this cycle (dp_op_e)
//   a_load_i  in   operand A captured on DP_LOAD
//   b_load_i  in   operand B captured on DP_LOAD
//   a_o       out  current A register (holds the gcd once B reaches 0)
//   cnt_o     out  steps taken since the last load
//   a_lt_b_o  out  A < B (unsigned)
//   b_eq_0_o  out  B == 0
module gcd_engine_dp
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT,
  parameter int CW    = gcd_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  dp_op_e           op_i,
  input  logic [WIDTH-1:0] a_load_i,
  input  logic [WIDTH-1:0] b_load_i,
  output logic [WIDTH-1:0] a_o,
  output logic [CW-1:0]    cnt_o,
  output logic             a_lt_b_o,
  output logic             b_eq_0_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    case (op_i)
      DP_LOAD: begin
        a_d   = a_load_i;
        b_d   = b_load_i;
        cnt_d = '0;
      end
      DP_SWAP: begin
        a_d   = b_q;
        b_d   = a_q;
        cnt_d = cnt_q + CW'(1);
      end
      DP_SUB: begin
        // Only issued when A >= B, so the difference never wraps.
        a_d   = a_q - b_q;
        cnt_d = cnt_q + CW'(1);
      end
      default: begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign a_o      = a_q;
  assign cnt_o    = cnt_q;
  assign a_lt_b_o = (a_q < b_q);
  assign b_eq_0_o = (b_q == '0);

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - self-sequenced swap/subtract GCD engine with valid/ready handshakes
//
// Purpose:
//   Accepts an operand pair, iterates Euclid's swap/subtract method one
//   step per cycle, and presents gcd plus the number of CALC cycles used.
//   A synchronous abort drops a computation in progress.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  engine can accept operands (IDLE)
//   a_in       in   operand A
//   b_in       in   operand B
//   abort      in   drop the computation in progress (CALC only)
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   gcd        out  result
//   cycles     out  CALC cycles spent on this result
//   busy       out  computation in progress (CALC)
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT,
  parameter int CW    = gcd_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic [CW-1:0]    cycles,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  dp_op_e           dp_op;
  logic [WIDTH-1:0] dp_a;
  logic [CW-1:0]    dp_cnt;
  logic             a_lt_b;
  logic             b_eq_0;

  gcd_engine_dp #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .op_i     (dp_op),
    .a_load_i (a_in),
    .b_load_i (b_in),
    .a_o      (dp_a),
    .cnt_o    (dp_cnt),
    .a_lt_b_o (a_lt_b),
    .b_eq_0_o (b_eq_0)
  );

  always_comb begin
    state_d  = state_q;
    gcd_d    = gcd_q;
    cycles_d = cycles_q;
    dp_op    = DP_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dp_op   = DP_LOAD;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Abort beats every other branch and leaves A, B and cnt as they are.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (a_lt_b) begin
          dp_op = DP_SWAP;
        end else if (b_eq_0) begin
          // The terminating cycle itself counts as a CALC cycle.
          gcd_d    = dp_a;
          cycles_d = dp_cnt + CW'(1);
          state_d  = ST_DONE;
        end else begin
          dp_op = DP_SUB;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gcd_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      gcd_q    <= gcd_d;
      cycles_q <= cycles_d;
    end
  end

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign gcd       = gcd_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - self-checking bench for gcd_engine
module tb_gcd_engine;

  localparam int W      = 8;
  localparam int CWB    = W + 1;
  localparam int BUDGET = 2000;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   gcd;
  logic [CWB-1:0] cycles;
  logic           busy;

  gcd_engine #(
    .WIDTH (W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd       (gcd),
    .cycles    (cycles),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    int           c;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    int           c;
    int           stall;
  } vec_t;

  exp_t         sb_q[$];
  vec_t         vecs[9];
  int           n_checks;
  int           n_pass;
  logic [W-1:0] last_g;
  int           last_c;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: gcd by remainder Euclid; cycles by stepping the swap/subtract rule.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] g, output int c);
    int p, q, r, x, y, n;
    p = a; q = b;
    while (q != 0) begin
      r = p % q; p = q; q = r;
    end
    g = W'(p);
    x = a; y = b; n = 0;
    while (!(x >= y && y == 0)) begin
      if (x < y) begin r = x; x = y; y = r; end
      else x = x - y;
      n++;
    end
    c = n + 1;
  endtask

  // Scoreboard monitor: compares every result at its handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_nonempty", longint'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_gcd", gcd, e.g);
        check("sb_cycles", cycles, e.c);
      end
    end
  end

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eg, input int ec,
                         input int stall, input bit chk_timing);
    int t, lat, bc;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = (stall == 0);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < BUDGET) begin
      @(negedge clk); t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back('{eg, ec});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = W'($urandom);
    b_in = W'($urandom);
    lat = 1; bc = 0;
    @(negedge clk);
    while (!out_valid && lat < BUDGET) begin
      if (busy) bc++;
      @(posedge clk); #1; lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      sb_q.delete();
      return;
    end
    if (chk_timing) begin
      check("latency", lat, ec + 1);
      check("busy_cycles", bc, ec);
    end
    for (int i = 0; i < stall; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_gcd", gcd, eg);
      check("stall_cycles", cycles, ec);
      @(posedge clk); #1;
      if (i == stall - 1) out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("in_ready_after_result", in_ready, 1);
    check("out_valid_after_result", out_valid, 0);
    last_g = eg;
    last_c = ec;
  endtask

  task automatic start_long_run(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    check("interrupt_accept_ready", in_ready, 1);
    @(posedge clk); #1;  // accept edge, CALC cycle 1 follows
    in_valid = 1'b0;
    @(posedge clk); #1;  // CALC cycle 2
    @(posedge clk); #1;  // CALC cycle 3
  endtask

  initial begin
    vecs[0] = '{8'd27,  8'd15, 8'd3,  10,  0};
    vecs[1] = '{8'd0,   8'd0,  8'd0,  1,   0};
    vecs[2] = '{8'd5,   8'd0,  8'd5,  1,   1};
    vecs[3] = '{8'd0,   8'd7,  8'd7,  2,   0};
    vecs[4] = '{8'd12,  8'd18, 8'd6,  7,   5};
    vecs[5] = '{8'd1,   8'd1,  8'd1,  3,   2};
    vecs[6] = '{8'd8,   8'd4,  8'd4,  4,   0};
    vecs[7] = '{8'd100, 8'd75, 8'd25, 7,   1};
    vecs[8] = '{8'd255, 8'd1,  8'd1,  257, 0};

    n_checks = 0; n_pass = 0;
    last_g = '0; last_c = 0;
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
    abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_gcd", gcd, 0);
    check("rst_cycles", cycles, 0);

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].c, vecs[i].stall, 1'b1);

    // Abort in the third CALC cycle: back to IDLE, old result kept.
    begin
      bit ov_seen;
      start_long_run(8'd63, 8'd1);
      abort = 1'b1;
      @(negedge clk);
      check("abort_busy_before", busy, 1);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_gcd_kept", gcd, last_g);
      check("abort_cycles_kept", cycles, last_c);
      ov_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        ov_seen |= out_valid;
        @(negedge clk);
      end
      check("abort_no_out_valid", ov_seen, 0);
    end

    // Reset in the third CALC cycle: everything back to reset values.
    start_long_run(8'd63, 8'd1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_gcd", gcd, 0);
    check("midrst_cycles", cycles, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_after", in_ready, 1);

    // Random pairs with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb, rg;
      int rc;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      ref_model(ra, rb, rg, rc);
      run_vec(ra, rb, rg, rc, $urandom_range(0, 3), 1'b0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
